eth_fcs_check: RTL
==================

Name: eth_fcs_check

Overview:
- Receive-side counterpart of the byte-wise CRC-32 generator used on transmit.
- Takes a received Ethernet frame as a byte stream that still carries its FCS, and checks the CRC-32 over the whole frame, FCS included, against the fixed residue.
- Strips the 4 FCS bytes with a 4-byte delay line and forwards only the payload.
- Reports per-frame status: CRC, length, PHY error, abort. Sits between the MAC receive deframer and the receive buffer; there is no backpressure.

Parameters:
- INIT, 32'hFFFFFFFF, CRC register preset at start of each frame.
- RESIDUE, 32'hDEBB20E3, expected CRC register value after the last FCS byte. Uncomplemented, reflected register.
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518, maximum legal frame length in bytes, FCS included.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  input byte strobe
- in_data  in  8  received byte; bit 0 was first on the wire
- in_sof  in  1  first byte of frame, qualified by in_valid
- in_eof  in  1  last byte of frame (last FCS byte), qualified by in_valid
- in_err  in  1  PHY error on this byte, qualified by in_valid
- out_valid  out  1  payload byte strobe
- out_data  out  8  payload byte
- out_sof  out  1  first payload byte
- out_eof  out  1  last payload byte
- stat_valid  out  1  one-cycle status pulse per frame
- stat_good  out  1  frame passed all checks
- stat_crc_err  out  1  residue mismatch
- stat_len_err  out  1  length < MIN_LEN or > MAX_LEN
- stat_phy_err  out  1  in_err seen during frame
- stat_abort  out  1  frame cut short by a new in_sof
- stat_len  out  16  frame length in bytes, FCS included, saturating at 16'hFFFF

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- All outputs reset to 0. The CRC register resets to INIT. Delay-line fill count resets to 0; state resets to IDLE.
- CRC algorithm: reflected CRC-32, polynomial 0xEDB88320, LSB of in_data first, 8 bit steps per valid byte, no final XOR.
  - A frame is correct iff the register equals RESIDUE after the in_eof byte.
- State machine, IDLE / INFRAME:
  - IDLE: bytes without in_sof are ignored. in_valid&in_sof starts a frame: CRC = step(INIT, byte), len = 1, fill = 1, flags cleared, go INFRAME.
  - INFRAME: each valid byte steps the CRC, increments len (saturating) and ORs in_err into the PHY flag.
  - in_sof&in_eof on the same byte: 1-byte frame, handled as the eof case below.
- Delay line: 4-byte FIFO of {byte, sof}.
  - A valid byte arriving with fill==4 pushes out the oldest entry. Next cycle: out_valid=1, out_data = that byte, out_sof = its sof tag.
  - Bytes arriving with fill<4 only fill the line.
  - Output latency is 1 cycle from the pushing input byte.
- eof byte arriving with fill==4:
  - The emitted byte is the last payload byte, so out_eof=1 together with out_valid next cycle.
  - The 4 remaining bytes are the FCS; they are discarded and fill is set to 0.
- eof byte arriving with fill<4 (frame < 5 bytes): no payload is output and no out_eof; stat_len_err=1.
- Status timing: stat_valid pulses exactly 1 cycle after the output cycle carrying out_eof. For short frames it pulses 2 cycles after the eof input.
  - stat_* fields hold their values until the next stat_valid.
  - stat_good = !(crc_err|len_err|phy_err|abort).
  - After eof the block returns to IDLE.
- in_sof while INFRAME (abort):
  - Current frame ends: stat_valid pulses 2 cycles later with stat_abort=1, stat_good=0, stat_crc_err=0. No out_eof is generated and buffered bytes are discarded.
  - The same byte starts the new frame, as from IDLE.
- Idle cycles (in_valid=0) inside a frame: no state change, no output.
- Back-to-back frames, with eof in cycle n and sof in cycle n+1, must work without loss.
- Reset mid-frame: everything is discarded and no stat_valid is issued.

Decomposition:
- Shared package eth_pkg holds:
  - CRC32_POLY_REFL = 32'hEDB88320, CRC32_INIT, CRC32_RESIDUE;
  - ETH_MIN_LEN, ETH_MAX_LEN;
  - a status struct type {good, crc_err, len_err, phy_err, abort, len[15:0]}.
- One combinational sub-module crc32_d8_refl computes next_crc from (crc[31:0], d[7:0]). The TX side can reuse it.
- The delay line and FSM stay in eth_fcs_check.

Test Plan:
- Good frame, MIN_LEN=5 override: sof + "123456789" (31..39) + FCS 26 39 F4 CB with eof.
  - Expect 9 out bytes 31..39, out_sof on 31 and out_eof on 39.
  - stat_valid 1 cycle later with good=1, len=13.
- Same frame with FCS byte CB changed to CA: identical payload output; stat_crc_err=1, good=0.
- 60-byte frame with valid FCS at default MIN_LEN: len_err=1, crc_err=0, len=60, payload 56 bytes. A 1519-byte frame: len_err=1.
- in_err on byte 20 of a valid 64-byte frame: phy_err=1, good=0; payload still forwarded, 60 bytes.
- New in_sof at byte 30 of a frame:
  - stat_abort=1, no out_eof for the first frame.
  - The following valid 64-byte frame yields good=1.
- Back-to-back valid frames with 0 idle cycles and random in_valid gaps inside frames: two good stat pulses, payload bit-exact. 3-byte frame: no out_valid, len_err=1, len=3.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions: CRC-32 constants, frame length
// limits and the per-frame status record.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1518;

    typedef struct packed {
        logic        good;
        logic        crc_err;
        logic        len_err;
        logic        phy_err;
        logic        abort;
        logic [15:0] len;
    } eth_stat_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_INFRAME = 1'b1
    } fcs_state_t;

endpackage

// File: rtl/crc32_d8_refl.sv
// One byte step of the reflected CRC-32 (LSB of the byte first), purely
// combinational so both the transmit generator and the receive checker can use it.
module crc32_d8_refl
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  d_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'd0, d_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_fcs_check.sv
// Receive FCS checker: runs CRC-32 over the whole frame including the FCS,
// strips the 4 FCS bytes through a delay line and reports per-frame status.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | between frames; bytes without in_sof are dropped
// ST_INFRAME | frame in progress; bytes step the CRC and feed the delay line
module eth_fcs_check
    import eth_pkg::*;
#(
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE,
    parameter int          MIN_LEN = ETH_MIN_LEN,
    parameter int          MAX_LEN = ETH_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic        in_err,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        stat_valid,
    output logic        stat_good,
    output logic        stat_crc_err,
    output logic        stat_len_err,
    output logic        stat_phy_err,
    output logic        stat_abort,
    output logic [15:0] stat_len
);

    localparam logic [15:0] MIN_LEN_W = MIN_LEN[15:0];
    localparam logic [15:0] MAX_LEN_W = MAX_LEN[15:0];

    fcs_state_t      state_q, state_d;
    logic [31:0]     crc_q, crc_d;
    logic [15:0]     len_q, len_d;
    logic            phy_q, phy_d;
    logic [2:0]      fill_q, fill_d;
    logic [3:0][7:0] dl_data_q, dl_data_d;
    logic [3:0]      dl_sof_q, dl_sof_d;

    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eof_q, out_eof_d;

    logic            pend_valid_q, pend_valid_d;
    eth_stat_t       pend_q, pend_d;
    logic            stat_valid_q, stat_valid_d;
    eth_stat_t       stat_q, stat_d;

    logic            accept;
    logic [31:0]     crc_in;
    logic [31:0]     crc_next;
    logic [15:0]     len_new;
    logic            phy_new;
    logic [2:0]      fill_base;

    assign accept = in_valid && (in_sof || (state_q == ST_INFRAME));
    assign crc_in = in_sof ? INIT : crc_q;

    crc32_d8_refl u_crc (
        .crc_i (crc_in),
        .d_i   (in_data),
        .crc_o (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        len_d        = len_q;
        phy_d        = phy_q;
        fill_d       = fill_q;
        dl_data_d    = dl_data_q;
        dl_sof_d     = dl_sof_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        pend_valid_d = 1'b0;
        pend_d       = pend_q;
        stat_valid_d = pend_valid_q;
        stat_d       = pend_valid_q ? pend_q : stat_q;
        len_new      = len_q;
        phy_new      = phy_q;
        fill_base    = fill_q;

        if (accept) begin
            // A start byte always discards whatever the line still holds.
            if (in_sof) begin
                len_new   = 16'd1;
                phy_new   = in_err;
                fill_base = 3'd0;
            end else begin
                len_new = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                phy_new = phy_q | in_err;
            end
            crc_d = crc_next;
            len_d = len_new;
            phy_d = phy_new;

            if (fill_base == 3'd4) begin
                out_valid_d = 1'b1;
                out_data_d  = dl_data_q[0];
                out_sof_d   = dl_sof_q[0];
            end

            if (in_eof) begin
                // The eof byte and the three still buffered are the FCS.
                out_eof_d      = (fill_base == 3'd4);
                fill_d         = 3'd0;
                state_d        = ST_IDLE;
                pend_valid_d   = 1'b1;
                pend_d.crc_err = (crc_next != RESIDUE);
                pend_d.len_err = (len_new < MIN_LEN_W) || (len_new > MAX_LEN_W);
                pend_d.phy_err = phy_new;
                pend_d.abort   = 1'b0;
                pend_d.len     = len_new;
            end else begin
                state_d = ST_INFRAME;
                if (fill_base == 3'd4) begin
                    dl_data_d = {in_data, dl_data_q[3], dl_data_q[2], dl_data_q[1]};
                    dl_sof_d  = {in_sof, dl_sof_q[3:1]};
                end else begin
                    dl_data_d[fill_base[1:0]] = in_data;
                    dl_sof_d[fill_base[1:0]]  = in_sof;
                    fill_d                    = fill_base + 3'd1;
                end
                if (in_sof && (state_q == ST_INFRAME)) begin
                    pend_valid_d   = 1'b1;
                    pend_d.crc_err = 1'b0;
                    pend_d.len_err = 1'b0;
                    pend_d.phy_err = phy_q;
                    pend_d.abort   = 1'b1;
                    pend_d.len     = len_q;
                end
            end
            // sof+eof on one byte while in a frame reports the 1-byte frame only.
            pend_d.good = !(pend_d.crc_err || pend_d.len_err ||
                            pend_d.phy_err || pend_d.abort);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            crc_q        <= INIT;
            len_q        <= 16'd0;
            phy_q        <= 1'b0;
            fill_q       <= 3'd0;
            dl_data_q    <= '0;
            dl_sof_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            stat_valid_q <= 1'b0;
            stat_q       <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            len_q        <= len_d;
            phy_q        <= phy_d;
            fill_q       <= fill_d;
            dl_data_q    <= dl_data_d;
            dl_sof_q     <= dl_sof_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            stat_valid_q <= stat_valid_d;
            stat_q       <= stat_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_sof      = out_sof_q;
    assign out_eof      = out_eof_q;
    assign stat_valid   = stat_valid_q;
    assign stat_good    = stat_q.good;
    assign stat_crc_err = stat_q.crc_err;
    assign stat_len_err = stat_q.len_err;
    assign stat_phy_err = stat_q.phy_err;
    assign stat_abort   = stat_q.abort;
    assign stat_len     = stat_q.len;

endmodule
